// File: rtl/sentry_muldiv_arbiter.sv
// sentry_muldiv_arbiter: round-robin sharing of one sentry_muldiv_unit among
// NUM_REQ operand-routing requesters, with an in-order tag FIFO that steers
// each md_done/md_out completion back to the requester that issued it.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   req_*               per-lane request bundle, lane i at [i*W +: W]
//   req_ready           one-hot grant (combinational)
//   resp_valid/data     one-hot registered result strobe and shared result
//   md_req, md_req_*    issue strobe and granted fields to the unit
//   md_ready            unit accepts a request this cycle
//   md_done, md_out     unit completion and result
//   err_orphan          sticky: md_done seen with no outstanding tag
//   perf_issue_cnt      per-lane issue counters (32 bits each)
//   perf_stall_cnt      cycles with a pending request but no issue
//
// Optional feature: define MD_ARB_PERF_EN to build the performance counters;
// otherwise both perf ports are tied to zero.

module sentry_muldiv_arbiter #(
    parameter int NUM_REQ          = 4,
    parameter int TAG_DEPTH        = 8,
    parameter int MD_OP_WIDTH      = 4,
    parameter int MD_OUT_SEL_WIDTH = 2
) (
    input  logic                                clk,
    input  logic                                rst,

    input  logic [NUM_REQ-1:0]                  req_valid,
    input  logic [NUM_REQ*MD_OP_WIDTH-1:0]      req_op,
    input  logic [NUM_REQ-1:0]                  req_srclow,
    input  logic [NUM_REQ-1:0]                  req_src1_signed,
    input  logic [NUM_REQ-1:0]                  req_src2_signed,
    input  logic [NUM_REQ*64-1:0]               req_src1,
    input  logic [NUM_REQ*64-1:0]               req_src2,
    input  logic [NUM_REQ*MD_OUT_SEL_WIDTH-1:0] req_out_sel,
    output logic [NUM_REQ-1:0]                  req_ready,
    output logic [NUM_REQ-1:0]                  resp_valid,
    output logic [63:0]                         resp_data,

    output logic                                md_req,
    output logic [MD_OP_WIDTH-1:0]              md_req_op,
    output logic                                md_req_srclow,
    output logic                                md_req_src1_signed,
    output logic                                md_req_src2_signed,
    output logic [63:0]                         md_req_src1,
    output logic [63:0]                         md_req_src2,
    output logic [MD_OUT_SEL_WIDTH-1:0]         md_req_out_sel,
    input  logic                                md_ready,
    input  logic                                md_done,
    input  logic [63:0]                         md_out,

    output logic                                err_orphan,
    output logic [NUM_REQ*32-1:0]               perf_issue_cnt,
    output logic [31:0]                         perf_stall_cnt
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int AW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
    localparam int OW = MD_OP_WIDTH;
    localparam int SW = MD_OUT_SEL_WIDTH;

    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] rr_next;
    logic [IW-1:0] grant_idx;
    logic [IW-1:0] sel_idx;
    logic [IW-1:0] head_tag;
    logic          grant_vld;
    logic          can_issue;
    logic          issue;
    logic          pop;
    logic          orphan;
    logic          tag_full;
    logic          tag_empty;

    logic [IW-1:0] tag_mem [TAG_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   tag_cnt;

    // Lane visited k steps after base in the circular scan.
    function automatic logic [IW-1:0] lane_at(input logic [IW-1:0] base,
                                              input int k);
        logic [IW:0] s;
        s = {1'b0, base} + (IW+1)'(k);
        if (s >= (IW+1)'(NUM_REQ)) s = s - (IW+1)'(NUM_REQ);
        return s[IW-1:0];
    endfunction

    // Fullness uses the registered count, so a same-cycle pop cannot
    // open a slot for a push.
    assign tag_full  = (tag_cnt == (AW+1)'(TAG_DEPTH));
    assign tag_empty = (tag_cnt == '0);
    assign can_issue = md_ready && !tag_full && !rst;

    always_comb begin
        grant_vld = 1'b0;
        grant_idx = rr_ptr;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (can_issue && !grant_vld && req_valid[lane_at(rr_ptr, k)]) begin
                grant_vld = 1'b1;
                grant_idx = lane_at(rr_ptr, k);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (grant_vld) req_ready = NUM_REQ'(1) << grant_idx;
    end

    assign issue  = |(req_valid & req_ready);
    assign md_req = issue;

    // Idle cycles present the rr_ptr lane so the mux select stays in range.
    assign sel_idx = grant_vld ? grant_idx : rr_ptr;

    assign md_req_op          = req_op[int'(sel_idx)*OW +: OW];
    assign md_req_srclow      = req_srclow[sel_idx];
    assign md_req_src1_signed = req_src1_signed[sel_idx];
    assign md_req_src2_signed = req_src2_signed[sel_idx];
    assign md_req_src1        = req_src1[int'(sel_idx)*64 +: 64];
    assign md_req_src2        = req_src2[int'(sel_idx)*64 +: 64];
    assign md_req_out_sel     = req_out_sel[int'(sel_idx)*SW +: SW];

    assign rr_next = (grant_idx == IW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

    assign head_tag = tag_mem[rd_ptr];
    assign pop      = md_done && !tag_empty;
    assign orphan   = md_done && tag_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr  <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            tag_cnt <= '0;
        end else begin
            if (issue) begin
                rr_ptr <= rr_next;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            unique case ({issue, pop})
                2'b10:   tag_cnt <= tag_cnt + 1'b1;
                2'b01:   tag_cnt <= tag_cnt - 1'b1;
                default: tag_cnt <= tag_cnt;
            endcase
        end
    end

    // Tag storage needs no reset; occupancy is tracked by tag_cnt.
    always_ff @(posedge clk) begin
        if (issue) tag_mem[wr_ptr] <= grant_idx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid <= '0;
            resp_data  <= '0;
            err_orphan <= 1'b0;
        end else begin
            resp_valid <= pop ? (NUM_REQ'(1) << head_tag) : '0;
            if (pop) resp_data <= md_out;
            if (orphan) err_orphan <= 1'b1;
        end
    end

`ifdef MD_ARB_PERF_EN
    logic [31:0] issue_cnt [NUM_REQ];
    logic [31:0] stall_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REQ; i++) issue_cnt[i] <= '0;
            stall_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (issue && grant_idx == IW'(i))
                    issue_cnt[i] <= issue_cnt[i] + 32'd1;
            end
            if (|req_valid && !md_req) stall_cnt <= stall_cnt + 32'd1;
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_perf
        assign perf_issue_cnt[g*32 +: 32] = issue_cnt[g];
    end
    assign perf_stall_cnt = stall_cnt;
`else
    assign perf_issue_cnt = '0;
    assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_sentry_muldiv_arbiter.sv
// Directed testbench for sentry_muldiv_arbiter (NUM_REQ=4, TAG_DEPTH=8).
// Inputs change 1 time unit after the rising edge; outputs sampled after.

module tb_sentry_muldiv_arbiter;

    localparam int N  = 4;
    localparam int OW = 4;
    localparam int SW = 2;

`ifdef MD_ARB_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req_valid;
    logic [N*OW-1:0]   req_op;
    logic [N-1:0]      req_srclow;
    logic [N-1:0]      req_src1_signed;
    logic [N-1:0]      req_src2_signed;
    logic [N*64-1:0]   req_src1;
    logic [N*64-1:0]   req_src2;
    logic [N*SW-1:0]   req_out_sel;
    logic [N-1:0]      req_ready;
    logic [N-1:0]      resp_valid;
    logic [63:0]       resp_data;
    logic              md_req;
    logic [OW-1:0]     md_req_op;
    logic              md_req_srclow;
    logic              md_req_src1_signed;
    logic              md_req_src2_signed;
    logic [63:0]       md_req_src1;
    logic [63:0]       md_req_src2;
    logic [SW-1:0]     md_req_out_sel;
    logic              md_ready;
    logic              md_done;
    logic [63:0]       md_out;
    logic              err_orphan;
    logic [N*32-1:0]   perf_issue_cnt;
    logic [31:0]       perf_stall_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sentry_muldiv_arbiter #(
        .NUM_REQ(N), .TAG_DEPTH(8),
        .MD_OP_WIDTH(OW), .MD_OUT_SEL_WIDTH(SW)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_op(req_op), .req_srclow(req_srclow),
        .req_src1_signed(req_src1_signed), .req_src2_signed(req_src2_signed),
        .req_src1(req_src1), .req_src2(req_src2), .req_out_sel(req_out_sel),
        .req_ready(req_ready), .resp_valid(resp_valid), .resp_data(resp_data),
        .md_req(md_req), .md_req_op(md_req_op), .md_req_srclow(md_req_srclow),
        .md_req_src1_signed(md_req_src1_signed),
        .md_req_src2_signed(md_req_src2_signed),
        .md_req_src1(md_req_src1), .md_req_src2(md_req_src2),
        .md_req_out_sel(md_req_out_sel),
        .md_ready(md_ready), .md_done(md_done), .md_out(md_out),
        .err_orphan(err_orphan), .perf_issue_cnt(perf_issue_cnt),
        .perf_stall_cnt(perf_stall_cnt)
    );

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        req_valid = '0;
        md_ready = 1'b0;
        md_done = 1'b0;
        md_out = '0;
        for (int i = 0; i < N; i++) begin
            req_op[i*OW +: OW]      = OW'(i + 8);
            req_srclow[i]           = i[0];
            req_src1_signed[i]      = i[1];
            req_src2_signed[i]      = ~i[0];
            req_src1[i*64 +: 64]    = 64'hA000 + 64'(i);
            req_src2[i*64 +: 64]    = 64'hB000 + 64'(i);
            req_out_sel[i*SW +: SW] = SW'(i);
        end

        // Reset state; grants suppressed while rst is high
        tick();
        tick();
        req_valid = 4'hF;
        md_ready = 1'b1;
        #1;
        chk("rst_req_ready", 128'(req_ready), 128'h0);
        chk("rst_md_req", 128'(md_req), 128'h0);
        chk("rst_resp_valid", 128'(resp_valid), 128'h0);
        chk("rst_resp_data", 128'(resp_data), 128'h0);
        chk("rst_err_orphan", 128'(err_orphan), 128'h0);
        chk("rst_perf_issue", perf_issue_cnt, 128'h0);
        chk("rst_perf_stall", 128'(perf_stall_cnt), 128'h0);

        // Round robin with all lanes valid: 0,1,2,3,0,1,2,3
        rst = 1'b0;
        #1;
        for (int k = 0; k < 8; k++) begin
            chk("rr_grant", 128'(req_ready), 128'(4'b0001 << (k % 4)));
            chk("rr_md_req", 128'(md_req), 128'h1);
            chk("rr_src1", 128'(md_req_src1), 128'(64'hA000 + 64'(k % 4)));
            chk("rr_op", 128'(md_req_op), 128'((k % 4) + 8));
            tick();
        end

        // Tag FIFO full: ninth request blocked, pop does not unblock it
        chk("full_block", 128'(req_ready), 128'h0);
        chk("full_md_req", 128'(md_req), 128'h0);
        md_done = 1'b1;
        md_out = 64'h1234;
        #1;
        chk("pop_no_unblock", 128'(req_ready), 128'h0);
        tick();
        md_done = 1'b0;
        #1;
        chk("first_resp_valid", 128'(resp_valid), 128'h1);
        chk("first_resp_data", 128'(resp_data), 128'h1234);
        chk("unblocked_grant", 128'(req_ready), 128'h1);
        tick();
        req_valid = '0;
        chk("resp_pulse_end", 128'(resp_valid), 128'h0);
        chk("resp_data_hold", 128'(resp_data), 128'h1234);

        // Drain: remaining tags 1,2,3,0,1,2,3 then the re-issued 0
        for (int k = 0; k < 8; k++) begin
            md_done = 1'b1;
            md_out = 64'h50 + 64'(k);
            tick();
            chk("drain_valid", 128'(resp_valid), 128'(4'b0001 << ((k + 1) % 4)));
            chk("drain_data", 128'(resp_data), 128'(64'h50 + 64'(k)));
        end
        md_done = 1'b0;
        tick();
        chk("drain_idle", 128'(resp_valid), 128'h0);

        // Orphan completion with empty FIFO
        md_done = 1'b1;
        md_out = 64'hDEAD;
        tick();
        md_done = 1'b0;
        chk("orphan_set", 128'(err_orphan), 128'h1);
        chk("orphan_no_resp", 128'(resp_valid), 128'h0);
        tick();
        tick();
        chk("orphan_sticky", 128'(err_orphan), 128'h1);
        chk("orphan_data_hold", 128'(resp_data), 128'h57);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("orphan_cleared", 128'(err_orphan), 128'h0);
        chk("rst_data_clear", 128'(resp_data), 128'h0);

        // md_ready low for 5 cycles with lanes 0 and 1 valid
        req_valid = 4'b0011;
        md_ready = 1'b0;
        #1;
        for (int k = 0; k < 5; k++) begin
            chk("stall_no_grant", 128'(req_ready), 128'h0);
            tick();
        end
        req_valid = '0;
        chk("stall_cnt", 128'(perf_stall_cnt), PERF ? 128'd5 : 128'd0);

        // Lane 2 alone from rr_ptr 0, then from rr_ptr 3, then 0 vs 2
        md_ready = 1'b1;
        req_valid = 4'b0100;
        #1;
        chk("l2_grant_a", 128'(req_ready), 128'b0100);
        chk("l2_src2", 128'(md_req_src2), 128'hB002);
        tick();
        chk("l2_grant_b", 128'(req_ready), 128'b0100);
        tick();
        req_valid = 4'b0101;
        #1;
        chk("wrap_grant_l0", 128'(req_ready), 128'b0001);
        chk("wrap_src1", 128'(md_req_src1), 128'hA000);
        tick();
        req_valid = '0;
        chk("perf_issue", perf_issue_cnt,
            PERF ? {32'd0, 32'd2, 32'd0, 32'd1} : 128'h0);

        // Reset with 3 tags in flight
        rst = 1'b1;
        req_valid = 4'hF;
        #1;
        chk("rst_mid_grant", 128'(req_ready), 128'h0);
        tick();
        chk("rst_mid_resp", 128'(resp_valid), 128'h0);
        chk("rst_mid_orphan", 128'(err_orphan), 128'h0);
        rst = 1'b0;
        #1;
        chk("post_rst_grant", 128'(req_ready), 128'h1);
        req_valid = '0;
        md_done = 1'b1;
        tick();
        md_done = 1'b0;
        chk("post_rst_empty", 128'(err_orphan), 128'h1);
        chk("post_rst_no_resp", 128'(resp_valid), 128'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
